// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment score display: digit count,
// score ceiling, active-low segment patterns and the converter FSM states.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int SCORE_MAX  = 9999;

    // Segment order {g,f,e,d,c,b,a}, active-low (0 = lit)
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD
    } conv_state_t;

    // BCD nibble to segment pattern; non-decimal nibbles go dark
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a single overwriting pending slot.
// bcd is the accumulator; it is only meaningful while bcd_vld is high (LOAD).
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W = 14   // must be at least 14 so SCORE_MAX fits
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] score,
    input  logic             score_vld,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_vld,
    output logic             busy
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t      state;
    logic [BIN_W-1:0] sreg;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic [CNT_W-1:0] cnt;
    logic             pend_vld;
    logic [BIN_W-1:0] pend_val;

    function automatic logic [BIN_W-1:0] clamp(input logic [BIN_W-1:0] v);
        return (v > BIN_W'(SCORE_MAX)) ? BIN_W'(SCORE_MAX) : v;
    endfunction

    assign bcd = acc;

    // Add-3 correction on every nibble that would overflow after the shift
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM; busy/bcd_vld are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            pend_vld <= 1'b0;
            pend_val <= '0;
            busy     <= 1'b0;
            bcd_vld  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (score_vld) begin
                        sreg  <= clamp(score);
                        acc   <= '0;
                        cnt   <= CNT_W'(BIN_W);
                        state <= ST_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (score_vld) begin
                        pend_vld <= 1'b1;
                        pend_val <= clamp(score);
                    end
                    acc  <= {acc_adj[BCD_W-2:0], sreg[BIN_W-1]};
                    sreg <= {sreg[BIN_W-2:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state   <= ST_LOAD;
                        bcd_vld <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    bcd_vld <= 1'b0;
                    // A strobe landing in LOAD is newer than the slot, so it wins
                    if (score_vld || pend_vld) begin
                        sreg     <= score_vld ? clamp(score) : pend_val;
                        acc      <= '0;
                        cnt      <= CNT_W'(BIN_W);
                        pend_vld <= 1'b0;
                        state    <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    bcd_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg7_score_display.sv
// Four-digit common-anode score display: binary score -> BCD -> scanned an/seg.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_score_display
    import seg7_pkg::*;
#(
    parameter int BIN_W      = 14,
    parameter int SCAN_DIV_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] score,
    input  logic             score_vld,
    output logic             busy,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    logic [BCD_W-1:0]      bcd;
    logic                  conv_vld;
    logic [BCD_W-1:0]      disp_bcd;
    logic [SCAN_DIV_W-1:0] scan_cnt;
    logic [1:0]            dig_idx;
    logic [3:0]            nib;
    logic                  blank;

    bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
        .clk       (clk),
        .rst       (rst),
        .score     (score),
        .score_vld (score_vld),
        .bcd       (bcd),
        .bcd_vld   (conv_vld),
        .busy      (busy)
    );

    // Display register only moves on a finished conversion
    always_ff @(posedge clk) begin
        if (rst)           disp_bcd <= '0;
        else if (conv_vld) disp_bcd <= bcd;
    end

    // Free-running prescaler; digit index steps on wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            if (&scan_cnt) dig_idx <= dig_idx + 1'b1;
        end
    end

    assign nib = disp_bcd[dig_idx*4 +: 4];

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;

    // A digit is dark when it and everything above it is zero; units never
    always_comb begin
        lz    = '0;
        lz[3] = (disp_bcd[15:12] == 4'd0);
        lz[2] = lz[3] && (disp_bcd[11:8] == 4'd0);
        lz[1] = lz[2] && (disp_bcd[7:4] == 4'd0);
        blank = lz[dig_idx];
    end
`else
    assign blank = 1'b0;
`endif

    // Registered anode/segment drive
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << dig_idx);
            seg <= blank ? SEG_BLANK : seg_decode(nib);
        end
    end

endmodule

// File: tb/tb_seg7_score_display.sv
// Bench for seg7_score_display with a fast scan (8 clocks per digit).
// Expected BCD values are queued at strobe time and popped on each LOAD.
module tb_seg7_score_display;

    localparam int BIN_W      = 14;
    localparam int SCAN_DIV_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [BIN_W-1:0] score;
    logic             score_vld;
    logic             busy;
    logic [3:0]       an;
    logic [6:0]       seg;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int load_cyc = 0;
    bit load_seen = 0;
    logic [15:0] exp_q[$];
    logic [6:0]  disp_seg[4];

    seg7_score_display #(.BIN_W(BIN_W), .SCAN_DIV_W(SCAN_DIV_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .score     (score),
        .score_vld (score_vld),
        .busy      (busy),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        logic [15:0] r;
        c = (v > 9999) ? 9999 : v;
        r[15:12] = 4'((c / 1000) % 10);
        r[11:8]  = 4'((c / 100) % 10);
        r[7:4]   = 4'((c / 10) % 10);
        r[3:0]   = 4'(c % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected pattern for digit i of a BCD word, honouring blanking if built in
    function automatic logic [6:0] exp_digit(input logic [15:0] b, input int i);
        logic [15:0] upper;
        upper = b >> (i * 4);
`ifdef SEG7_LZ_BLANK_EN
        if (i != 0 && upper == 16'd0) return 7'b1111111;
`endif
        return seg_of(upper[3:0]);
    endfunction

    // Scoreboard: the cycle after LOAD, disp_bcd must hold the oldest expectation
    always @(negedge clk) begin
        if (load_seen) begin
            if (exp_q.size() == 0) chk("unexp_load", 32'(dut.disp_bcd), 32'hdead);
            else                   chk("disp_bcd", 32'(dut.disp_bcd), 32'(exp_q.pop_front()));
        end
        load_seen = dut.conv_vld;
        if (dut.conv_vld) load_cyc = cyc;
    end

    task automatic strobe(input int v, input bit replace);
        if (replace && exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(to_bcd(v));
        score     = BIN_W'(v);
        score_vld = 1'b1;
        @(posedge clk);
        #1 score_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Capture each digit's segments over a full scan period
    task automatic read_disp();
        for (int i = 0; i < 4; i++) disp_seg[i] = 7'h55;
        repeat (40) begin
            @(negedge clk);
            case (an)
                4'b1110: disp_seg[0] = seg;
                4'b1101: disp_seg[1] = seg;
                4'b1011: disp_seg[2] = seg;
                4'b0111: disp_seg[3] = seg;
                default: ;
            endcase
        end
    endtask

    task automatic check_disp(input string tag, input logic [15:0] b);
        read_disp();
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_dig%0d", tag, i), 32'(disp_seg[i]), 32'(exp_digit(b, i)));
    endtask

    initial begin
        int t0;
        int nb;
        rst = 1'b1;
        score = '0;
        score_vld = 1'b0;

        // Reset state and scan order
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hf);
        chk("rst_seg", 32'(seg), 32'h7f);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_an", 32'(an), 32'b1110);
        chk("rel_seg", 32'(seg), 32'b1000000);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("scan_an1", 32'(an), 32'b1101);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("scan_an2", 32'(an), 32'b1011);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("scan_an3", 32'(an), 32'b0111);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("scan_wrap", 32'(an), 32'b1110);

        // Single conversion: busy width, latency and digits
        t0 = cyc;
        strobe(1234, 1'b0);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
        end
        chk("busy_len", 32'(nb), 32'd15);
        chk("load_lat", 32'(load_cyc - t0), 32'd15);
        wait_idle();
        check_disp("d1234", to_bcd(1234));

        // Clamp
        strobe(16383, 1'b0);
        wait_idle();
        check_disp("clamp", to_bcd(9999));

        // Overlap: 7 is overwritten by 815 before it can start
        strobe(42, 1'b0);
        nb = 0;
        for (int i = 1; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            @(posedge clk);
            #1;
            if (i == 3) begin
                exp_q.push_back(to_bcd(7));
                score = BIN_W'(7);
                score_vld = 1'b1;
            end else if (i == 5) begin
                void'(exp_q.pop_back());
                exp_q.push_back(to_bcd(815));
                score = BIN_W'(815);
                score_vld = 1'b1;
            end else begin
                score_vld = 1'b0;
            end
        end
        score_vld = 1'b0;
        chk("b2b_busy", 32'(nb), 32'd30);
        wait_idle();
        check_disp("d815", to_bcd(815));

        // Leading zeros
        strobe(5, 1'b0);
        wait_idle();
        check_disp("d5", to_bcd(5));

        // Abort mid-conversion
        strobe(99, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_disp", 32'(dut.disp_bcd), 32'd0);
        repeat (25) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        check_disp("abort", 16'h0000);

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule

// File: doc/seg7_score_display.md
# seg7_score_display

Score display driver for the four-digit, common-anode seven-segment display on the board. It accepts a binary score from the game logic and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes the four digits onto `an`/`seg`. This is the transmitting end of the display interface that the top level exposes as `an[3:0]`/`seg[6:0]`.

## Interface
- `BIN_W`, default 14: score input width, unsigned.
- `SCAN_DIV_W`, default 17: scan prescaler width. The digit advances once every 2^SCAN_DIV_W clocks, which is about 1.31 ms at 100 MHz.
- `clk`, input, 1: system clock. This is the single clock domain.
- `rst`, input, 1: reset, synchronous, active-high.
- `score`, input, BIN_W: binary score to display.
- `score_vld`, input, 1: single-cycle strobe that requests display of `score`.
- `busy`, output, 1: high while a conversion is in progress.
- `an`, output, 4: digit enables, active-low. `an[0]` is the rightmost digit (units).
- `seg`, output, 7: segments `{g,f,e,d,c,b,a}`, active-low.

## Operation
- Input capture
  - A `score` value above 9999 is clamped to 9999 at capture.
- Conversion FSM. States are IDLE, SHIFT and LOAD.
  - IDLE to SHIFT: on `score_vld`. The clamped score goes into the shift register, the BCD accumulator is cleared, and the bit counter is set to BIN_W.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift left by one. The counter decrements. SHIFT exits to LOAD after BIN_W cycles.
  - LOAD: the 16-bit BCD result is copied to the display register `disp_bcd`. The FSM then returns to IDLE, or re-enters SHIFT if a pending request exists.
- Requests while busy
  - `score_vld` during SHIFT or LOAD stores the value in a single pending slot.
  - A later strobe overwrites the pending value; only the last value is kept.
  - The pending value is consumed in LOAD, which goes directly to SHIFT with no IDLE cycle.
- Scan
  - A free-running SCAN_DIV_W-bit counter runs continuously. On wrap-around, the digit index advances 0→1→2→3→0.
  - `an` is the active-low one-hot of the digit index.
  - `seg` is the decoded nibble of `disp_bcd`.
  - Encoding:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
    - Nibbles 10–15 cannot occur; they decode to 1111111.
- Decoupling
  - Scanning never stalls for a conversion.
  - `disp_bcd` changes only in LOAD, so a half-converted value is never displayed.

## Timing
- Reset values
  - `an`=1111, `seg`=1111111, `busy`=0.
  - `disp_bcd`=0, digit index 0, scan counter 0, pending slot empty, FSM in IDLE.
- Display after reset
  - `an`/`seg` are registered.
  - On the first cycle after `rst` deasserts, `an`=1110 and `seg`=1000000, showing "0".
- Latency
  - `score_vld` is sampled at edge N.
  - `busy` is high from N+1 through N+BIN_W+1. LOAD occupies cycle N+BIN_W+1.
  - `disp_bcd` is valid at N+BIN_W+2.
  - The new value reaches `seg` at the next registered output update, N+BIN_W+3.
- Back-to-back: a pending request keeps `busy` high continuously. There is no gap cycle.
- `rst` mid-conversion: the conversion aborts and the pending request is dropped. All state returns to reset values on the next edge.
- `score_vld` coincident with `rst`: ignored.

## Configuration
- `SEG7_LZ_BLANK_EN`
  - Defined: leading zeros are blanked. A digit whose nibble and all more-significant nibbles are 0 drives `seg`=1111111, while `an` still scans. Digit 0 is never blanked, so a score of 0 shows "0".
  - Undefined: all four digits are always shown, so a score of 0 shows "0000".

## Structure
- Package `seg7_pkg` holds:
  - The segment encoding constants.
  - `NUM_DIGITS`=4.
  - `SCORE_MAX`=9999.
  - The FSM state enum.
- Sub-module `bin2bcd_seq` holds the double-dabble FSM, shift register and pending slot. Its interface is `score`/`score_vld` in and `bcd`/`bcd_vld`/`busy` out.
- The top of this block holds the scan counter, digit mux, blanking and the output registers.

## Test plan
- Reset
  - Stimulus: assert `rst` with SCAN_DIV_W=3.
  - Expect: `an`=1111 and `seg`=1111111 during reset. After release, `an`=1110 and `seg`=1000000. `an` steps 1101, 1011, 0111 every 8 clocks.
- Single conversion
  - Stimulus: `score`=1234 with `score_vld` at N.
  - Expect: `busy` is high for 15 cycles and `disp_bcd`=16'h1234 at N+16. Digit 0 shows 0011001 (4) and digit 3 shows 1111001 (1).
- Clamp
  - Stimulus: `score`=16383.
  - Expect: `disp_bcd`=16'h9999.
- Overlap
  - Stimulus: strobe 42, then 7 and 815 while busy.
  - Expect: the display shows 42 and then 815. 7 is never displayed. `busy` has no low gap between the two conversions.
- Blanking (macro defined)
  - Stimulus: `score`=5.
  - Expect: digits 3–1 `seg`=1111111, digit 0 `seg`=0010010.
  - Without the macro, digits 3–1 show 1000000.
- Abort
  - Stimulus: pulse `rst` 5 cycles after strobing 99.
  - Expect: `disp_bcd` stays 0, `busy`=0 and the display shows "0".
